// File: rtl/pfxsum_pkg.sv
// pfxsum_pkg: default widths, stage count and adder mode for the prefix-sum stream.
// Define PFXSUM_SAT_EN to make every addition saturate instead of wrapping.
package pfxsum_pkg;
    localparam int IWIDTH_D = 8;
    localparam int OWIDTH_D = 16;
    localparam int V_LEN_D = 8;
`ifdef PFXSUM_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif
    function automatic int stage_count(input int v_len);
        return $clog2(v_len);
    endfunction
endpackage

// File: rtl/pfxsum_if.sv
// pfxsum_if: beat bundle of pfxsum_stream; slave is the block side, master the driving side.
interface pfxsum_if #(
    parameter int IWIDTH = pfxsum_pkg::IWIDTH_D,
    parameter int OWIDTH = pfxsum_pkg::OWIDTH_D,
    parameter int V_LEN = pfxsum_pkg::V_LEN_D
);
    logic valid_in;
    logic ready_in;
    logic [IWIDTH*V_LEN-1:0] ivec;
    logic first_in;
    logic excl_in;
    logic valid_out;
    logic ready_out;
    logic [OWIDTH*V_LEN-1:0] ovec;
    modport slave(input valid_in, ivec, first_in, excl_in, ready_out, output ready_in, valid_out, ovec);
    modport master(output valid_in, ivec, first_in, excl_in, ready_out, input ready_in, valid_out, ovec);
endinterface

// File: rtl/pfxsum_stage.sv
// pfxsum_stage: one Kogge-Stone doubling stage (element i += element i-SHIFT) with its valid/stall register.
module pfxsum_stage #(
    parameter int OWIDTH = pfxsum_pkg::OWIDTH_D,
    parameter int V_LEN = pfxsum_pkg::V_LEN_D,
    parameter int SHIFT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic prev_valid,
    input  logic prev_first,
    input  logic prev_excl,
    input  logic [V_LEN-1:0][OWIDTH-1:0] prev_data,
    output logic valid,
    output logic first,
    output logic excl,
    output logic [V_LEN-1:0][OWIDTH-1:0] data
);
    import pfxsum_pkg::*;
    function automatic logic [OWIDTH-1:0] add(input logic [OWIDTH-1:0] a, input logic [OWIDTH-1:0] b);
        logic [OWIDTH:0] s;
        s = a + b;
        return (SAT_EN && s[OWIDTH]) ? '1 : s[OWIDTH-1:0];
    endfunction
    logic [V_LEN-1:0][OWIDTH-1:0] sum;
    for (genvar i = 0; i < V_LEN; i++) begin : g_el
        if (i >= SHIFT) begin : g_add
            assign sum[i] = add(prev_data[i], prev_data[i-SHIFT]);
        end else begin : g_pass
            assign sum[i] = prev_data[i];
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            valid <= 1'b0;
            first <= 1'b0;
            excl <= 1'b0;
            data <= '0;
        end else if (en) begin
            valid <= prev_valid;
            first <= prev_first;
            excl <= prev_excl;
            data <= sum;
        end
endmodule

// File: rtl/pfxsum_stream.sv
// pfxsum_stream: streaming V_LEN-wide inclusive/exclusive prefix sum with a carry chained across beats.
// PFXSUM_SAT_EN (resolved in pfxsum_pkg) switches every addition from wrap to saturate.
module pfxsum_stream #(
    parameter int IWIDTH = pfxsum_pkg::IWIDTH_D,
    parameter int OWIDTH = pfxsum_pkg::OWIDTH_D,
    parameter int V_LEN = pfxsum_pkg::V_LEN_D
) (
    input logic clk,
    input logic rst_n,
    pfxsum_if.slave bus
);
    import pfxsum_pkg::*;
    localparam int N = stage_count(V_LEN);
    function automatic logic [OWIDTH-1:0] add(input logic [OWIDTH-1:0] a, input logic [OWIDTH-1:0] b);
        logic [OWIDTH:0] s;
        s = a + b;
        return (SAT_EN && s[OWIDTH]) ? '1 : s[OWIDTH-1:0];
    endfunction
    logic [N:0] v, f, x;
    logic [N:0][V_LEN-1:0][OWIDTH-1:0] d;
    logic [V_LEN-1:0][OWIDTH-1:0] ext, d0, base, res;
    logic v0, f0, x0, en;
    logic [OWIDTH-1:0] c, ce;
    assign en = !(v[N] && !bus.ready_out);
    assign bus.ready_in = en;
    assign bus.valid_out = v[N];
    always_comb begin
        ext = '0;
        for (int i = 0; i < V_LEN; i++)
            ext[i] = OWIDTH'(bus.ivec[i*IWIDTH +: IWIDTH]);
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v0 <= 1'b0;
            f0 <= 1'b0;
            x0 <= 1'b0;
            d0 <= '0;
        end else if (en) begin
            v0 <= bus.valid_in;
            f0 <= bus.first_in;
            x0 <= bus.excl_in;
            d0 <= ext;
        end
    assign v[0] = v0;
    assign f[0] = f0;
    assign x[0] = x0;
    assign d[0] = d0;
    for (genvar k = 1; k <= N; k++) begin : g_stage
        pfxsum_stage #(.OWIDTH(OWIDTH), .V_LEN(V_LEN), .SHIFT(1 << (k-1))) u_stage (
            .clk(clk),
            .rst_n(rst_n),
            .en(en),
            .prev_valid(v[k-1]),
            .prev_first(f[k-1]),
            .prev_excl(x[k-1]),
            .prev_data(d[k-1]),
            .valid(v[k]),
            .first(f[k]),
            .excl(x[k]),
            .data(d[k])
        );
    end
    // Exclusive mode reuses the inclusive scan shifted up one element.
    assign ce = f[N] ? '0 : c;
    assign base = x[N] ? {d[N][V_LEN-2:0], OWIDTH'(0)} : d[N];
    always_comb begin
        res = '0;
        for (int i = 0; i < V_LEN; i++)
            res[i] = add(ce, base[i]);
    end
    assign bus.ovec = res;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            c <= '0;
        else if (v[N] && bus.ready_out)
            c <= add(ce, d[N][V_LEN-1]);
endmodule
